// File: rtl/timer_entry_pkg.sv
// Shared definitions for the microwave timer keypad front end: key codes,
// controller state encoding and BCD digit helpers.
package timer_entry_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam logic [3:0] KEY_CLEAR      = 4'hA;
  localparam logic [3:0] KEY_ENTER      = 4'hB;
  localparam bcd_t       QUICK_SEC_TENS = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ARM   = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/timer_entry_key_edge.sv
// Registered rising-edge detector for a level-type button or keypad strobe;
// a held level yields a single one-cycle rise.
module key_edge (
  input  logic i_clk,
  input  logic i_clrn,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_clrn) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/timer_entry.sv
// Keypad entry controller for the MM:SS countdown digit chain.
// Macro TIMER_ENTRY_QUICKSTART_EN: ENTER in IDLE loads 00:30.
//   IDLE  | no entry, digits zero
//   ENTRY | digits being keyed in, shifted from sec_ones
//   LOAD  | loadn low for one cycle
//   ARM   | waiting for the timer chain to start counting
//   RUN   | timer counting, keypad locked
module timer_entry
  import timer_entry_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_SEC_TENS = 5
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_busy,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       entry_active,
  output logic       err
);

  state_t     r_state;
  bcd_t       r_min_tens;
  bcd_t       r_min_ones;
  bcd_t       r_sec_tens;
  bcd_t       r_sec_ones;
  logic [2:0] r_count;
  logic       r_loadn;
  logic       r_entry_active;
  logic       r_err;

  logic w_press;
  logic w_digit_press;
  logic w_clear_press;
  logic w_enter_press;
  logic w_has_room;
  logic w_sec_tens_bad;

  key_edge u_key_edge (
    .i_clk   (clk),
    .i_clrn  (clrn),
    .i_level (key_valid),
    .o_rise  (w_press)
  );

  assign w_digit_press  = w_press & is_digit(key_code);
  assign w_clear_press  = w_press & (key_code == KEY_CLEAR);
  assign w_enter_press  = w_press & (key_code == KEY_ENTER);
  assign w_has_room     = r_count < 3'(NUM_DIGITS);
  assign w_sec_tens_bad = r_sec_tens > 4'(MAX_SEC_TENS);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state        <= ST_IDLE;
      r_min_tens     <= '0;
      r_min_ones     <= '0;
      r_sec_tens     <= '0;
      r_sec_ones     <= '0;
      r_count        <= '0;
      r_loadn        <= 1'b1;
      r_entry_active <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_loadn <= 1'b1;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_digit_press) begin
            r_sec_ones     <= key_code;
            r_count        <= 3'd1;
            r_entry_active <= 1'b1;
            r_state        <= ST_ENTRY;
          end
`ifdef TIMER_ENTRY_QUICKSTART_EN
          else if (w_enter_press) begin
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= QUICK_SEC_TENS;
            r_sec_ones <= '0;
            r_loadn    <= 1'b0;
            r_state    <= ST_LOAD;
          end
`endif
        end
        ST_ENTRY: begin
          if (w_digit_press) begin
            if (w_has_room) begin
              r_min_tens <= r_min_ones;
              r_min_ones <= r_sec_tens;
              r_sec_tens <= r_sec_ones;
              r_sec_ones <= key_code;
              r_count    <= r_count + 3'd1;
            end
          end else if (w_clear_press) begin
            r_min_tens     <= '0;
            r_min_ones     <= '0;
            r_sec_tens     <= '0;
            r_sec_ones     <= '0;
            r_count        <= '0;
            r_entry_active <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (w_enter_press) begin
            if (w_sec_tens_bad) begin
              r_err <= 1'b1;
            end else begin
              r_loadn        <= 1'b0;
              r_entry_active <= 1'b0;
              r_state        <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_ARM;
        end
        ST_ARM: begin
          // An abort from the keypad wins over the chain starting this cycle.
          if (w_clear_press) begin
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_count    <= '0;
            r_state    <= ST_IDLE;
          end else if (timer_busy) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!timer_busy) begin
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_count    <= '0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_min_tens     <= '0;
          r_min_ones     <= '0;
          r_sec_tens     <= '0;
          r_sec_ones     <= '0;
          r_count        <= '0;
          r_entry_active <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign min_tens     = r_min_tens;
  assign min_ones     = r_min_ones;
  assign sec_tens     = r_sec_tens;
  assign sec_ones     = r_sec_ones;
  assign loadn        = r_loadn;
  assign entry_active = r_entry_active;
  assign err          = r_err;

endmodule

// File: tb/tb_timer_entry.sv
// Scoreboard bench for timer_entry: a decimal-value entry model predicts
// each cycle's outputs and every load; a negedge monitor checks them.
module tb_timer_entry;

`ifdef TIMER_ENTRY_QUICKSTART_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       timer_busy = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       loadn, entry_active, err;

  always #5 clk = ~clk;

  timer_entry dut (
    .clk          (clk),
    .clrn         (clrn),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .timer_busy   (timer_busy),
    .min_tens     (min_tens),
    .min_ones     (min_ones),
    .sec_tens     (sec_tens),
    .sec_ones     (sec_ones),
    .loadn        (loadn),
    .entry_active (entry_active),
    .err          (err)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        loadn;
    logic        err;
    logic        ea;
  } snap_t;

  snap_t       exp_q[$];
  logic [15:0] load_q[$];
  int total = 0;
  int bad   = 0;

  // Model: the entry is a decimal number (MMSS), the controller a phase.
  localparam int PH_IDLE = 0, PH_ENTER = 1, PH_LOADING = 2, PH_ARMED = 3, PH_RUNNING = 4;
  int m_phase = PH_IDLE;
  int m_value = 0;
  int m_ndig  = 0;
  bit m_prev  = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input bit rn, input bit kv, input logic [3:0] code, input bit busy);
    snap_t s;
    bit press;
    bit ld = 1'b0;
    bit er = 1'b0;
    if (!rn) begin
      m_phase = PH_IDLE; m_value = 0; m_ndig = 0; m_prev = 1'b0;
    end else begin
      press  = kv && !m_prev;
      m_prev = kv;
      case (m_phase)
        PH_IDLE: begin
          if (press && code <= 4'd9) begin
            m_value = int'(code); m_ndig = 1; m_phase = PH_ENTER;
          end else if (press && code == 4'hB && QUICK) begin
            m_value = 30; m_phase = PH_LOADING; ld = 1'b1;
          end
        end
        PH_ENTER: begin
          if (press && code <= 4'd9) begin
            if (m_ndig < 4) begin
              m_value = m_value * 10 + int'(code);
              m_ndig++;
            end
          end else if (press && code == 4'hA) begin
            m_value = 0; m_ndig = 0; m_phase = PH_IDLE;
          end else if (press && code == 4'hB) begin
            if ((m_value / 10) % 10 > 5) er = 1'b1;
            else begin m_phase = PH_LOADING; ld = 1'b1; end
          end
        end
        PH_LOADING: m_phase = PH_ARMED;
        PH_ARMED: begin
          if (press && code == 4'hA) begin
            m_value = 0; m_ndig = 0; m_phase = PH_IDLE;
          end else if (busy) m_phase = PH_RUNNING;
        end
        default: begin
          if (!busy) begin
            m_value = 0; m_ndig = 0; m_phase = PH_IDLE;
          end
        end
      endcase
    end
    s.digits = to_bcd(m_value);
    s.loadn  = !ld;
    s.err    = er;
    s.ea     = (m_phase == PH_ENTER);
    exp_q.push_back(s);
    if (ld) load_q.push_back(s.digits);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  initial begin : monitor
    snap_t s;
    logic [15:0] ld_exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("digits", {min_tens, min_ones, sec_tens, sec_ones}, s.digits);
        chk("loadn", 16'(loadn), 16'(s.loadn));
        chk("err", 16'(err), 16'(s.err));
        chk("entry_active", 16'(entry_active), 16'(s.ea));
      end
      if (loadn === 1'b0) begin
        if (load_q.size() == 0) begin
          chk("unexpected_load", 16'(loadn), 16'h1);
        end else begin
          ld_exp = load_q.pop_front();
          chk("load_value", {min_tens, min_ones, sec_tens, sec_ones}, ld_exp);
        end
      end
    end
  end

  task automatic cyc(input bit rn, input bit kv, input logic [3:0] code, input bit busy);
    clrn = rn; key_valid = kv; key_code = code; timer_busy = busy;
    model_step(rn, kv, code, busy);
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input bit busy);
    cyc(1'b1, 1'b1, code, busy);
    cyc(1'b1, 1'b0, code, busy);
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 4'h0, busy);
  endtask

  initial begin : stim
    bit kv = 1'b0;
    bit bz = 1'b0;
    bit rn;
    logic [3:0] code = 4'h0;

    repeat (3) cyc(1'b0, 1'b0, 4'h0, 1'b0);
    idle(2, 1'b0);

    // 01:23 -> 12:30, load, arm, run, finish
    press(4'd1, 1'b0); press(4'd2, 1'b0); press(4'd3, 1'b0); press(4'd0, 1'b0);
    press(4'hB, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);
    idle(2, 1'b0);

    // seconds-tens of 9 is rejected
    press(4'd9, 1'b0); press(4'd9, 1'b0); press(4'hB, 1'b0);
    idle(2, 1'b0);
    press(4'hA, 1'b0);

    // fifth digit ignored, then CLEAR
    for (int d = 1; d <= 5; d++) press(4'(d), 1'b0);
    press(4'hA, 1'b0);

    // 00:05 run with keys pressed while locked
    press(4'd5, 1'b0); press(4'hB, 1'b0);
    idle(1, 1'b0);
    press(4'd3, 1'b1); press(4'hA, 1'b1); idle(1, 1'b1);
    idle(3, 1'b0);

    // held key gives one digit
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 4'd7, 1'b0);
    idle(2, 1'b0);
    press(4'hA, 1'b0);

    // ENTER in IDLE
    press(4'hB, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    idle(2, 1'b0);

    // reset during the LOAD cycle (entry path, then IDLE ENTER path)
    press(4'd4, 1'b0);
    cyc(1'b1, 1'b1, 4'hB, 1'b0);
    cyc(1'b0, 1'b0, 4'hB, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 1'b1, 4'hB, 1'b0);
    cyc(1'b0, 1'b0, 4'hB, 1'b0);
    idle(2, 1'b0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) kv = ~kv;
      if (!kv) code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) bz = ~bz;
      rn = ($urandom_range(0, 399) != 0);
      cyc(rn, kv, code, bz);
    end
    idle(3, 1'b0);

    @(negedge clk);
    #1;
    chk("exp_queue_drained", 16'(exp_q.size()), 16'h0);
    chk("load_queue_drained", 16'(load_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
